// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: opcodes, function codes,
// fetch-stage state encoding and the default reset PC.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/mips_ifetch_nextpc.sv
// Combinational next-PC selection: jump, taken branch or fall-through.
// All arithmetic wraps modulo 2^32.
module mips_nextpc (
    input  logic [31:0] pc,
    input  logic [25:0] instr,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] w_boff;
    logic [31:0] w_btgt;
    logic [31:0] w_jtgt;

    assign pc_plus4 = pc + 32'd4;
    assign w_boff   = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign w_btgt   = pc_plus4 + w_boff;
    assign w_jtgt   = {pc_plus4[31:28], instr[25:0], 2'b00};

    // Jump outranks a taken branch; otherwise fall through.
    always_comb begin
        next_pc = pc_plus4;
        priority case (1'b1)
            Jump:           next_pc = w_jtgt;
            Branch && Zero: next_pc = w_btgt;
            default:        next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/mips_ifetch.sv
// Instruction fetch stage: PC register, imem handshake, instruction register.
// Optional retire counter enabled by defining IFETCH_RETIRE_CNT_EN.
module mips_ifetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Zero,
    output logic [31:0] instr,
    output logic [5:0]  OprCtr,
    output logic [5:0]  funct,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16,
`ifdef IFETCH_RETIRE_CNT_EN
    output logic [31:0] retire_cnt,
`endif
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;
    logic [31:0]  w_next_pc;
    logic         w_capture;
    logic         w_accept;

    mips_nextpc u_nextpc (
        .pc       (r_pc),
        .instr    (r_instr[25:0]),
        .Branch   (Branch),
        .Jump     (Jump),
        .Zero     (Zero),
        .pc_plus4 (pc_plus4),
        .next_pc  (w_next_pc)
    );

    // State register; reset drops imem_req asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, handshake outputs and register enables.
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // PC advances only when decode accepts the held instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_pc <= RESET_PC;
        else if (w_accept) r_pc <= w_next_pc;
    end

    // Instruction register changes only on a fetch capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         r_instr <= 32'd0;
        else if (w_capture) r_instr <= imem_rdata;
    end

`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    // Count accepted instructions, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_retire_cnt <= 32'd0;
        else if (w_accept) r_retire_cnt <= r_retire_cnt + 32'd1;
    end

    assign retire_cnt = r_retire_cnt;
`endif

    assign pc        = r_pc;
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign OprCtr    = r_instr[31:26];
    assign rs        = r_instr[25:21];
    assign rt        = r_instr[20:16];
    assign rd        = r_instr[15:11];
    assign imm16     = r_instr[15:0];
    assign funct     = r_instr[5:0];

endmodule

// File: tb/tb_mips_ifetch.sv
// Directed testbench for mips_ifetch and its next-PC unit.
// Retire counter checks are compiled in with IFETCH_RETIRE_CNT_EN.
module tb_mips_ifetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        Branch, Jump, Zero;
    logic [31:0] instr;
    logic [5:0]  OprCtr, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] pc, pc_plus4;
`ifdef IFETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    logic [31:0] np_pc;
    logic [25:0] np_instr;
    logic        np_b, np_j, np_z;
    logic [31:0] np_p4, np_next;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] I_ADDI = 32'h2008_0005;
    localparam logic [31:0] I_J100 = 32'h0800_0040;
    localparam logic [31:0] I_BEQ  = 32'h1000_FFFE;

    always #5 clk = ~clk;

    mips_ifetch #(.RESET_PC(32'h0000_0040)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .Branch      (Branch),
        .Jump        (Jump),
        .Zero        (Zero),
        .instr       (instr),
        .OprCtr      (OprCtr),
        .funct       (funct),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .imm16       (imm16),
`ifdef IFETCH_RETIRE_CNT_EN
        .retire_cnt  (retire_cnt),
`endif
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    mips_nextpc u_np (
        .pc       (np_pc),
        .instr    (np_instr),
        .Branch   (np_b),
        .Jump     (np_j),
        .Zero     (np_z),
        .pc_plus4 (np_p4),
        .next_pc  (np_next)
    );

    task automatic deliver(input logic [31:0] w);
        imem_ack   = 1'b1;
        imem_rdata = w;
        @(posedge clk); #1;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
    endtask

    task automatic accept(input logic b, input logic j, input logic z);
        Branch = b; Jump = j; Zero = z;
        instr_ready = 1'b1;
        @(posedge clk); #1;
        instr_ready = 1'b0;
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'd0; instr_ready = 1'b0;
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", instr_valid); end
        total++; if (pc !== 32'h40) begin bad++; $display("FAIL rst_pc got=%h exp=00000040", pc); end
        total++; if (instr !== 32'd0) begin bad++; $display("FAIL rst_instr got=%h exp=0", instr); end
        total++; if (OprCtr !== 6'd0) begin bad++; $display("FAIL rst_opr got=%b exp=0", OprCtr); end
        total++; if (pc_plus4 !== 32'h44) begin bad++; $display("FAIL rst_pc4 got=%h exp=00000044", pc_plus4); end
`ifdef IFETCH_RETIRE_CNT_EN
        total++; if (retire_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", retire_cnt); end
`endif
        rst_n = 1'b1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        @(posedge clk); #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem_req); end
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL first_addr got=%h exp=00000040", imem_addr); end
    endtask

    task automatic test_zero_wait;
        deliver(I_ADDI);
        total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL zw_valid got=%b exp=1", instr_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL zw_req got=%b exp=0", imem_req); end
        total++; if (OprCtr !== 6'b001000) begin bad++; $display("FAIL zw_opr got=%b exp=001000", OprCtr); end
        total++; if (rt !== 5'd8 || rs !== 5'd0 || rd !== 5'd0) begin bad++; $display("FAIL zw_regs got=%0d/%0d/%0d exp=0/8/0", rs, rt, rd); end
        total++; if (imm16 !== 16'd5 || funct !== 6'd5) begin bad++; $display("FAIL zw_imm got=%h/%h exp=0005/05", imm16, funct); end
        accept(1'b0, 1'b0, 1'b0);
        total++; if (pc !== 32'h44) begin bad++; $display("FAIL zw_pc got=%h exp=00000044", pc); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin bad++; $display("FAIL zw_next got=%b/%h exp=1/00000044", imem_req, imem_addr); end
        total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL zw_drop got=%b exp=0", instr_valid); end
    endtask

    task automatic test_stall;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h44 || instr_valid !== 1'b0) begin
                bad++; $display("FAIL stall_%0d got=%b/%h/%b exp=1/00000044/0", i, imem_req, imem_addr, instr_valid);
            end
            @(posedge clk); #1;
        end
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h44) begin bad++; $display("FAIL stall_ack got=%b/%h exp=1/00000044", imem_req, imem_addr); end
        deliver(I_J100);
        total++; if (instr_valid !== 1'b1 || instr !== I_J100) begin bad++; $display("FAIL stall_cap got=%b/%h exp=1/%h", instr_valid, instr, I_J100); end
        accept(1'b0, 1'b1, 1'b0);
        total++; if (pc !== 32'h100) begin bad++; $display("FAIL jump_pc got=%h exp=00000100", pc); end
    endtask

    task automatic test_hold;
        deliver(I_BEQ);
        Branch = 1'b1; Jump = 1'b1; Zero = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; end
            @(posedge clk); #1;
            imem_ack = 1'b0;
            total++;
            if (instr !== I_BEQ || pc !== 32'h100 || imem_req !== 1'b0 || instr_valid !== 1'b1) begin
                bad++; $display("FAIL hold_%0d got=%h/%h/%b/%b exp=%h/00000100/0/1", i, instr, pc, imem_req, instr_valid, I_BEQ);
            end
        end
        Branch = 1'b0; Jump = 1'b0; Zero = 1'b0;
    endtask

    task automatic test_branch;
        accept(1'b1, 1'b0, 1'b1);
        total++; if (pc !== 32'hFC || imem_addr !== 32'hFC) begin bad++; $display("FAIL beq_taken got=%h exp=000000fc", imem_addr); end
        deliver(I_J100);
        accept(1'b0, 1'b1, 1'b0);
        deliver(I_BEQ);
        accept(1'b1, 1'b0, 1'b0);
        total++; if (imem_addr !== 32'h104) begin bad++; $display("FAIL beq_not got=%h exp=00000104", imem_addr); end
        deliver(I_J100);
        accept(1'b1, 1'b1, 1'b1);
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL jump_wins got=%h exp=00000100", imem_addr); end
    endtask

    task automatic test_reset_mid_fetch;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL mid_pre got=%b exp=1", imem_req); end
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req got=%b exp=0", imem_req); end
        total++; if (pc !== 32'h40 || instr !== 32'd0) begin bad++; $display("FAIL mid_regs got=%h/%h exp=00000040/0", pc, instr); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL mid_restart got=%b/%h exp=1/00000040", imem_req, imem_addr); end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) begin
            deliver(I_ADDI);
            if (i == 4) begin
                repeat (3) @(posedge clk);
                #1;
            end
            accept(1'b0, 1'b0, 1'b0);
        end
        total++; if (pc !== 32'h68) begin bad++; $display("FAIL b2b_pc got=%h exp=00000068", pc); end
`ifdef IFETCH_RETIRE_CNT_EN
        total++; if (retire_cnt !== 32'd10) begin bad++; $display("FAIL retire_cnt got=%0d exp=10", retire_cnt); end
`endif
    endtask

    task automatic test_nextpc_unit;
        np_pc = 32'h9000_0010; np_instr = I_J100[25:0];
        np_b = 1'b0; np_j = 1'b1; np_z = 1'b0;
        #1;
        total++; if (np_next !== 32'h9000_0100) begin bad++; $display("FAIL np_jump_hi got=%h exp=90000100", np_next); end
        np_pc = 32'hFFFF_FFFC; np_j = 1'b0;
        #1;
        total++; if (np_p4 !== 32'd0 || np_next !== 32'd0) begin bad++; $display("FAIL np_wrap got=%h/%h exp=0/0", np_p4, np_next); end
        np_instr = 26'h000_0001; np_b = 1'b1; np_z = 1'b1;
        #1;
        total++; if (np_next !== 32'h4) begin bad++; $display("FAIL np_br_wrap got=%h exp=00000004", np_next); end
        np_pc = 32'd0; np_instr = 26'h000_8000;
        #1;
        total++; if (np_next !== 32'hFFFE_0004) begin bad++; $display("FAIL np_br_neg got=%h exp=fffe0004", np_next); end
    endtask

    initial begin
        np_pc = 32'd0; np_instr = 26'd0;
        np_b = 1'b0; np_j = 1'b0; np_z = 1'b0;
        test_reset;
        test_zero_wait;
        test_stall;
        test_hold;
        test_branch;
        test_reset_mid_fetch;
        test_back_to_back;
        test_nextpc_unit;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_ifetch.md
# mips_ifetch

Instruction fetch stage for the single-issue MIPS core. Holds the program counter, fetches one 32-bit instruction per handshake from instruction memory, presents it and its decoded fields to the decoder, and computes the next PC from the decoder's Branch/Jump outputs and the ALU zero flag. It sits directly upstream of the decoder: its OprCtr and funct outputs drive the decoder inputs, and the control signals the decoder produces close the loop.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word-aligned.
- clk  in  1  core clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request; held until imem_ack.
- imem_addr  out  32  byte address of the fetch, equals pc, stable while imem_req=1.
- imem_ack  in  1  one-cycle pulse: imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word.
- instr_valid  out  1  instruction register holds an instruction for decode.
- instr_ready  in  1  decode/execute accepts the presented instruction this cycle.
- Branch  in  1  from decoder, for the presented instruction.
- Jump  in  1  from decoder, for the presented instruction.
- Zero  in  1  ALU zero flag for the presented instruction.
- instr  out  32  instruction register.
- OprCtr  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- imm16  out  16  instr[15:0].
- pc  out  32  address of the presented or in-flight instruction.
- pc_plus4  out  32  pc + 4.

## Operation
- States: IDLE, FETCH, HOLD. Reset enters IDLE.
- IDLE: all outputs inactive; goes to FETCH on the first clock edge after rst_n deasserts.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack, capture imem_rdata into instr and go to HOLD.
- HOLD: instr_valid=1, imem_req=0. On instr_ready=1, load pc with next_pc and go to FETCH.
- next_pc priority:
  - Jump=1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else Branch & Zero: pc_plus4 + (sign_extend(imm16) << 2).
  - else pc_plus4.
- Arithmetic is 32-bit modulo 2^32. pc=32'hFFFF_FFFC gives pc_plus4=0, and branch targets wrap silently.
- Branch, Jump and Zero are sampled only in the HOLD cycle in which instr_ready=1; they are ignored at all other times.
- imem_ack is ignored in IDLE and HOLD.
- Branch=1 with Zero=0 falls through to pc_plus4. Jump and Branch together: Jump wins.

## Timing
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, state=IDLE. Field outputs follow instr and are therefore 0.
- First request: imem_req rises 1 cycle after reset release.
- imem_ack at edge N gives instr_valid=1 from cycle N+1. A zero-wait memory (ack in the first request cycle) yields one instruction every 2 cycles when instr_ready is tied high.
- instr_ready at edge M: pc updates at M, imem_req for the new pc is asserted in cycle M+1, and instr_valid drops in cycle M+1.
- instr is stable throughout HOLD and changes only on a FETCH capture.
- Reset mid-fetch: the outstanding request is abandoned and imem_req drops asynchronously. Instruction memory must tolerate a dropped request.

## Configuration
- IFETCH_RETIRE_CNT_EN defined:
  - Adds output retire_cnt, 32 bits, reset 0.
  - Increments by 1 on every HOLD cycle with instr_ready=1 and wraps at 2^32.
- Undefined: no port and no counter logic.

## Structure
- Shared package mips_pkg holds:
  - opcode constants: OP_RTYPE 6'b000000, OP_ADDI 6'b001000, OP_LW 6'b100011, OP_SW 6'b101011, OP_BEQ 6'b000100, OP_J 6'b000010;
  - funct constants;
  - the fetch state enum;
  - RESET_PC default.
- One sub-module, mips_nextpc: combinational next-PC logic (pc, instr, Branch, Jump, Zero -> next_pc). Kept separate so it can be unit-tested.

## Test plan
- Reset with RESET_PC=32'h0000_0040 and 0-wait memory returning 32'h2008_0005 (addi): imem_addr=0x40, then OprCtr=6'b001000, imem_addr=0x44 after ready.
- Memory stalls 3 cycles before ack: imem_req and imem_addr held constant for 4 cycles, instr_valid asserted exactly 1 cycle after the ack.
- beq at pc=0x100 with imm16=16'hFFFE, Branch=1, Zero=1 -> next fetch at 0xFC. Same instruction with Zero=0 -> next fetch at 0x104.
- j at pc=0x9000_0010 with target 26'h000_0040 -> next fetch at 0x9000_0100.
- instr_ready low for 5 cycles in HOLD: instr and pc unchanged, no imem_req. rst_n pulsed low during FETCH -> imem_req=0 immediately, then restart at RESET_PC.
- IFETCH_RETIRE_CNT_EN defined, 10 accepted instructions including one instr_ready stall -> retire_cnt=10.
